// File: rtl/aes_inv_key_schedule_if.sv
// Handshake bundle between the inverse key schedule and the inverse cipher core.
// The engine sits on the slave side; the load/consume agent sits on the master side.
interface aes_inv_key_schedule_if;
    logic         start;
    logic [127:0] key_last;
    logic         busy;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         done;

    modport master (
        output start, key_last, out_ready,
        input  busy, out_valid, round_key, round_idx, done
    );

    modport slave (
        input  start, key_last, out_ready,
        output busy, out_valid, round_key, round_idx, done
    );
endinterface

// File: rtl/aes_inv_key_schedule.sv
// AES-128 inverse key schedule: loaded with round key 10, it walks backward and
// presents round keys 10..0, one per accepted handshake.
module aes_inv_key_schedule (
    input  logic                        clk,
    input  logic                        rst,
    aes_inv_key_schedule_if.slave       bus
);
    typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

    state_t       state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   idx_q, idx_d;
    logic         done_q, done_d;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  p0, p1, p2, p3;
    logic [31:0]  rot_p3, sub_word;
    logic [7:0]   rcon;

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Forward S-box computed as x^254 (multiplicative inverse, 0 -> 0) then the affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] x2, x4, x8, x16, x32, x64, x128, inv;
        x2   = gf_mul(x, x);
        x4   = gf_mul(x2, x2);
        x8   = gf_mul(x4, x4);
        x16  = gf_mul(x8, x8);
        x32  = gf_mul(x16, x16);
        x64  = gf_mul(x32, x32);
        x128 = gf_mul(x64, x64);
        inv  = gf_mul(gf_mul(gf_mul(x2, x4), gf_mul(x8, x16)),
                      gf_mul(gf_mul(x32, x64), x128));
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    assign w0 = key_q[127:96];
    assign w1 = key_q[95:64];
    assign w2 = key_q[63:32];
    assign w3 = key_q[31:0];

    assign p3     = w3 ^ w2;
    assign p2     = w2 ^ w1;
    assign p1     = w1 ^ w0;
    assign rot_p3 = {p3[23:0], p3[31:24]};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sbox
            assign sub_word[8*gi +: 8] = sbox(rot_p3[8*gi +: 8]);
        end
    endgenerate

    always_comb begin
        rcon = 8'h00;
        case (idx_q)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign p0 = w0 ^ sub_word ^ {rcon, 24'h0};

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    key_d   = bus.key_last;
                    idx_d   = 4'd10;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (bus.out_ready) begin
                    if (idx_q != 4'd0) begin
                        key_d = {p0, p1, p2, p3};
                        idx_d = idx_q - 4'd1;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            key_q   <= 128'h0;
            idx_q   <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy      = (state_q == EMIT);
    assign bus.out_valid = (state_q == EMIT);
    assign bus.round_key = key_q;
    assign bus.round_idx = idx_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Directed bench for the AES-128 inverse key schedule using FIPS-197 vectors.
module tb_aes_inv_key_schedule;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aes_inv_key_schedule_if bus ();

    aes_inv_key_schedule dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    localparam logic [127:0] C1_K10 = 128'h13111D7F_E3944A17_F307A78B_4D2B30C5;
    localparam logic [127:0] C1_K1  = 128'hD6AA74FD_D2AF72FA_DAA678F1_D6AB76FE;
    localparam logic [127:0] C1_K0  = 128'h00010203_04050607_08090A0B_0C0D0E0F;
    localparam logic [127:0] A1_K10 = 128'hD014F9A8_C9EE2589_E13F0CC8_B6630CA6;
    localparam logic [127:0] A1_K9  = 128'hAC7766F3_19FADC21_28D12941_575C006E;
    localparam logic [127:0] A1_K0  = 128'h2B7E1516_28AED2A6_ABF71588_09CF4F3C;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One full run of keys 10..0. Optional stall, start poke while busy, and
    // a chained start issued in the done cycle (next call is then preloaded).
    task automatic run_seq(input string name, input logic [127:0] k,
                           input int ia, input logic [127:0] ka,
                           input logic [127:0] k0,
                           input int stall_at, input bit poke,
                           input bit preloaded, input bit chain,
                           input logic [127:0] chain_key);
        logic [127:0] held;
        if (!preloaded) begin
            @(negedge clk);
            bus.start     = 1'b1;
            bus.key_last  = k;
            bus.out_ready = 1'b1;
        end
        @(negedge clk);
        bus.start    = 1'b0;
        bus.key_last = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
        for (int e = 10; e >= 0; e--) begin
            check({name, " valid"}, bus.out_valid, 1'b1);
            check({name, " busy"},  bus.busy, 1'b1);
            check({name, " idx"},   bus.round_idx, e);
            check({name, " done_low"}, bus.done, 1'b0);
            if (e == 10) check({name, " key10"}, bus.round_key, k);
            if (e == ia) check({name, " key_a"}, bus.round_key, ka);
            if (e == 0)  check({name, " key0"},  bus.round_key, k0);
            $display("%s idx %0d key %h", name, bus.round_idx, bus.round_key);
            if (e == stall_at) begin
                held = bus.round_key;
                bus.out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check({name, " stall_idx"},   bus.round_idx, e);
                    check({name, " stall_key"},   bus.round_key, held);
                    check({name, " stall_valid"}, bus.out_valid, 1'b1);
                end
                bus.out_ready = 1'b1;
            end
            bus.start = (poke && e == 7);
            @(negedge clk);
            bus.start = 1'b0;
        end
        check({name, " done"},       bus.done, 1'b1);
        check({name, " end_valid"},  bus.out_valid, 1'b0);
        check({name, " end_busy"},   bus.busy, 1'b0);
        check({name, " end_idx"},    bus.round_idx, 4'd0);
        check({name, " end_key"},    bus.round_key, k0);
        if (chain) begin
            bus.start    = 1'b1;
            bus.key_last = chain_key;
        end else begin
            @(negedge clk);
            check({name, " done_once"}, bus.done, 1'b0);
            check({name, " idle_valid"}, bus.out_valid, 1'b0);
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.key_last  = 128'h0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst busy",  bus.busy, 1'b0);
        check("rst valid", bus.out_valid, 1'b0);
        check("rst done",  bus.done, 1'b0);
        check("rst idx",   bus.round_idx, 4'd0);
        check("rst key",   bus.round_key, 128'h0);
        rst = 1'b0;

        // C.1, then start in its done cycle launches A.1
        run_seq("c1", C1_K10, 1, C1_K1, C1_K0, -1, 1'b0, 1'b0, 1'b1, A1_K10);
        run_seq("a1", A1_K10, 9, A1_K9, A1_K0, -1, 1'b0, 1'b1, 1'b0, 128'h0);

        // Backpressure at idx 5 plus a start poke with another key at idx 7
        run_seq("c1_bp", C1_K10, 1, C1_K1, C1_K0, 5, 1'b1, 1'b0, 1'b0, 128'h0);

        // Reset in the middle of a run
        @(negedge clk);
        bus.start     = 1'b1;
        bus.key_last  = C1_K10;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (6) @(negedge clk);
        check("mid idx4", bus.round_idx, 4'd4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort busy",  bus.busy, 1'b0);
        check("abort valid", bus.out_valid, 1'b0);
        check("abort done",  bus.done, 1'b0);
        check("abort idx",   bus.round_idx, 4'd0);
        check("abort key",   bus.round_key, 128'h0);
        @(negedge clk);
        check("abort no_done", bus.done, 1'b0);
        run_seq("c1_after", C1_K10, 1, C1_K1, C1_K0, -1, 1'b0, 1'b0, 1'b0, 128'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
